score_counter: RTL and testbench

Up/down event counter that turns two raw push-button inputs into the 10-bit binary value for the decimal 7-segment display stage. Each qualified press increments or decrements a saturating count. The registered count drives the display converter's `data_in` directly. The block sits between the board keys and the display path, and it owns synchronisation, optional debouncing, edge detection and the count register.

---
 rtl/score_pkg.sv | 19 +
 rtl/score_counter_if.sv | 34 +++
 rtl/key_debounce.sv | 116 +++++++++++
 rtl/score_counter.sv | 88 ++++++++
 tb/tb_score_counter.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/score_pkg.sv
// Shared types and constants for the score counter and its key front-ends.
package score_pkg;

  // Width of the display count.
  localparam int unsigned CNT_W = 10;

  // Default build-time limits.
  localparam int unsigned MAX_COUNT_DEF       = 999;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;

  // Per-key debouncer states.
  typedef enum logic [1:0] {
    StStableHi,
    StWaitLo,
    StStableLo,
    StWaitHi
  } deb_state_e;

endpackage

// File: rtl/score_counter_if.sv
// Key inputs and count/flag outputs of the score counter, bundled for the display path.
interface score_counter_if;

  logic                         inc_key_n;
  logic                         dec_key_n;
  logic                         clear;
  logic [score_pkg::CNT_W-1:0]  count;
  logic                         at_max;
  logic                         at_min;
  logic                         sat_pulse;

  // Board / stimulus side.
  modport master (
    output inc_key_n,
    output dec_key_n,
    output clear,
    input  count,
    input  at_max,
    input  at_min,
    input  sat_pulse
  );

  // Counter side.
  modport slave (
    input  inc_key_n,
    input  dec_key_n,
    input  clear,
    output count,
    output at_max,
    output at_min,
    output sat_pulse
  );

endinterface

// File: rtl/key_debounce.sv
// One key front-end: 2-FF synchroniser, optional debouncer, falling-edge detector.
// The debouncer is compiled in when SCORE_COUNTER_DEBOUNCE_EN is defined;
// otherwise the qualified level is the synchronised level.
module key_debounce
  import score_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press_evt
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("key_debounce: DEBOUNCE_CYCLES must be >= 2");
  end

  logic [1:0] sync_q;
  logic       synced;
  logic       qualified;
  logic       hist_q;

  // Bring the raw key into the clock domain; idle (released) level is 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key_n};
    end
  end

  assign synced = sync_q[1];

`ifdef SCORE_COUNTER_DEBOUNCE_EN
  localparam int unsigned DebW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DebW-1:0] DebLast = DebW'(DEBOUNCE_CYCLES - 1);

  deb_state_e            state_q, state_d;
  logic      [DebW-1:0]  deb_cnt_q, deb_cnt_d;

  // Debounce state and stable-sample counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StStableHi;
      deb_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  // The sample that leaves a stable state counts as the first of the run,
  // so a new level is accepted on its DEBOUNCE_CYCLES-th consecutive sample.
  always_comb begin
    state_d   = state_q;
    deb_cnt_d = deb_cnt_q;
    qualified = 1'b1;
    unique case (state_q)
      StStableHi: begin
        qualified = 1'b1;
        if (!synced) begin
          state_d   = StWaitLo;
          deb_cnt_d = DebW'(1);
        end
      end
      StWaitLo: begin
        qualified = 1'b1;
        if (synced) begin
          state_d   = StStableHi;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DebLast) begin
          state_d   = StStableLo;
          deb_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      StStableLo: begin
        qualified = 1'b0;
        if (synced) begin
          state_d   = StWaitHi;
          deb_cnt_d = DebW'(1);
        end
      end
      StWaitHi: begin
        qualified = 1'b0;
        if (!synced) begin
          state_d   = StStableLo;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DebLast) begin
          state_d   = StStableHi;
          deb_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
    endcase
  end
`else
  assign qualified = synced;
`endif

  // Remember the previous qualified level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= 1'b1;
    end else begin
      hist_q <= qualified;
    end
  end

  // Press = released-to-pressed transition only.
  assign press_evt = hist_q & ~qualified;

endmodule

// File: rtl/score_counter.sv
// Saturating up/down score counter feeding the 7-segment display stage.
// Optional per-key debouncing is enabled with SCORE_COUNTER_DEBOUNCE_EN.
module score_counter
  import score_pkg::*;
#(
  parameter int unsigned MAX_COUNT       = MAX_COUNT_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input logic            clk,
  input logic            rst_n,
  score_counter_if.slave bus
);

  if (MAX_COUNT > 1023) begin : g_bad_max
    $error("score_counter: MAX_COUNT must be <= 1023");
  end

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_COUNT);

  logic             inc_evt;
  logic             dec_evt;
  logic [CNT_W-1:0] count_q, count_d;
  logic             at_max_q;
  logic             at_min_q;
  logic             sat_q, sat_d;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_inc_key (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_n     (bus.inc_key_n),
    .press_evt (inc_evt)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_dec_key (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_n     (bus.dec_key_n),
    .press_evt (dec_evt)
  );

  // Next count with clear > simultaneous > inc > dec priority; never wraps.
  always_comb begin
    count_d = count_q;
    sat_d   = 1'b0;
    if (bus.clear) begin
      count_d = '0;
    end else if (inc_evt && dec_evt) begin
      count_d = count_q;  // opposing presses cancel
    end else if (inc_evt) begin
      if (count_q < MaxCnt) begin
        count_d = count_q + 1'b1;
      end else begin
        sat_d = 1'b1;
      end
    end else if (dec_evt) begin
      if (count_q != '0) begin
        count_d = count_q - 1'b1;
      end else begin
        sat_d = 1'b1;
      end
    end
  end

  // Count and flags registered together so the flags always match the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      at_max_q <= 1'b0;
      at_min_q <= 1'b1;
      sat_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      at_max_q <= (count_d == MaxCnt);
      at_min_q <= (count_d == '0);
      sat_q    <= sat_d;
    end
  end

  assign bus.count     = count_q;
  assign bus.at_max    = at_max_q;
  assign bus.at_min    = at_min_q;
  assign bus.sat_pulse = sat_q;

endmodule

// File: tb/tb_score_counter.sv
// Directed self-checking bench for score_counter (MAX_COUNT=12, DEBOUNCE_CYCLES=4).
// Expected results follow SCORE_COUNTER_DEBOUNCE_EN as the RTL does.
module tb_score_counter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   sat_cnt;
  int   sat0;

`ifdef SCORE_COUNTER_DEBOUNCE_EN
  localparam int Lat       = 7;  // 3 + DEBOUNCE_CYCLES
  localparam int BounceInc = 1;
`else
  localparam int Lat       = 3;
  localparam int BounceInc = 2;
`endif

  score_counter_if bus ();

  score_counter #(
    .MAX_COUNT       (12),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count saturation pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.sat_pulse === 1'b1) sat_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit inc, input bit dec, input int lo, input int hi);
    @(negedge clk);
    if (inc) bus.inc_key_n = 1'b0;
    if (dec) bus.dec_key_n = 1'b0;
    cyc(lo);
    bus.inc_key_n = 1'b1;
    bus.dec_key_n = 1'b1;
    cyc(hi);
  endtask

  task automatic do_clear();
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    sat_cnt       = 0;
    rst_n         = 1'b0;
    bus.inc_key_n = 1'b1;
    bus.dec_key_n = 1'b1;
    bus.clear     = 1'b0;
    cyc(2);
    chk("reset_count", int'(bus.count), 0);
    chk("reset_at_max", int'(bus.at_max), 0);
    chk("reset_at_min", int'(bus.at_min), 1);
    chk("reset_sat", int'(bus.sat_pulse), 0);
    rst_n = 1'b1;
    cyc(2);

    // Reset in the middle of a press, key kept held afterwards.
    @(negedge clk);
    bus.inc_key_n = 1'b0;
    cyc(3);
    rst_n = 1'b0;
    cyc(1);
    chk("midpress_rst_count", int'(bus.count), 0);
    chk("midpress_rst_at_min", int'(bus.at_min), 1);
    rst_n = 1'b1;
    cyc(Lat - 1);
    chk("held_before_latency", int'(bus.count), 0);
    cyc(1);
    chk("held_at_latency", int'(bus.count), 1);
    cyc(10);
    chk("held_no_repeat", int'(bus.count), 1);
    bus.inc_key_n = 1'b1;
    cyc(8);
    chk("release_no_event", int'(bus.count), 1);

    // Clean presses.
    do_clear();
    chk("clear_count", int'(bus.count), 0);
    sat0 = sat_cnt;
    repeat (5) press(1'b1, 1'b0, 8, 8);
    chk("five_inc", int'(bus.count), 5);
    repeat (2) press(1'b0, 1'b1, 8, 8);
    chk("two_dec", int'(bus.count), 3);
    chk("clean_no_sat", sat_cnt - sat0, 0);

    // Bouncing inc key: 0,1,0 then held low.
    @(negedge clk);
    bus.inc_key_n = 1'b0;
    @(negedge clk);
    bus.inc_key_n = 1'b1;
    @(negedge clk);
    bus.inc_key_n = 1'b0;
    cyc(10);
    bus.inc_key_n = 1'b1;
    cyc(8);
    chk("bounce", int'(bus.count), 3 + BounceInc);

    // Upper saturation.
    do_clear();
    sat0 = sat_cnt;
    repeat (14) press(1'b1, 1'b0, 8, 8);
    chk("sat_hi_count", int'(bus.count), 12);
    chk("sat_hi_at_max", int'(bus.at_max), 1);
    chk("sat_hi_at_min", int'(bus.at_min), 0);
    chk("sat_hi_pulses", sat_cnt - sat0, 2);
    press(1'b0, 1'b1, 8, 8);
    chk("below_max_count", int'(bus.count), 11);
    chk("below_max_at_max", int'(bus.at_max), 0);

    // Lower saturation.
    do_clear();
    chk("clear_at_min", int'(bus.at_min), 1);
    sat0 = sat_cnt;
    press(1'b0, 1'b1, 8, 8);
    chk("sat_lo_count", int'(bus.count), 0);
    chk("sat_lo_at_min", int'(bus.at_min), 1);
    chk("sat_lo_pulses", sat_cnt - sat0, 1);

    // Simultaneous inc and dec at 6.
    do_clear();
    repeat (6) press(1'b1, 1'b0, 8, 8);
    chk("six_count", int'(bus.count), 6);
    sat0 = sat_cnt;
    press(1'b1, 1'b1, 8, 8);
    chk("both_count", int'(bus.count), 6);
    chk("both_no_sat", sat_cnt - sat0, 0);

    // Clear coinciding with an inc event at 9.
    do_clear();
    repeat (9) press(1'b1, 1'b0, 8, 8);
    chk("nine_count", int'(bus.count), 9);
    sat0 = sat_cnt;
    @(negedge clk);
    bus.inc_key_n = 1'b0;
    cyc(Lat - 1);
    chk("pre_clear_count", int'(bus.count), 9);
    bus.clear = 1'b1;
    cyc(1);
    bus.clear = 1'b0;
    chk("clear_vs_inc_count", int'(bus.count), 0);
    chk("clear_vs_inc_at_min", int'(bus.at_min), 1);
    cyc(10);
    bus.inc_key_n = 1'b1;
    cyc(8);
    chk("inc_lost", int'(bus.count), 0);
    chk("clear_no_sat", sat_cnt - sat0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
